// File: rtl/gray_seq_checker.sv
// Gray-coded count stream checker: decodes each valid word and classifies the step from the previous word.
// Optional macro GRAY_CHK_ERRCNT_EN adds the o_err_cnt port and a saturating CW-bit error counter.
module gray_seq_checker #(
    parameter int NBIT = 8,
    parameter int CW   = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NBIT-1:0] i_gray,
    input  logic            i_valid,
    input  logic            i_clr,
    output logic [NBIT-1:0] o_bin,
    output logic            o_valid,
    output logic            o_step_up,
    output logic            o_step_dn,
    output logic            o_hold,
    output logic            o_err,
    output logic            o_err_sticky
`ifdef GRAY_CHK_ERRCNT_EN
    ,
    output logic [CW-1:0]   o_err_cnt
`endif
);

    typedef enum logic {
        S_EMPTY,
        S_LOCK
    } state_t;

    state_t          state;
    logic [NBIT-1:0] gray_bin;
    logic [NBIT-1:0] r1_bin;
    logic            r1_vld;
    logic [NBIT-1:0] ref_bin;
    logic [NBIT-1:0] diff;

    // Binary bit k is the parity of all Gray bits at or above position k.
    always_comb begin
        gray_bin = '0;
        for (int k = 0; k < NBIT; k++) begin
            gray_bin[k] = ^(i_gray >> k);
        end
    end

    assign diff = r1_bin - ref_bin;

    // Stage 1: register the decoded word; a clear flushes it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r1_vld <= 1'b0;
            r1_bin <= '0;
        end else if (i_clr) begin
            r1_vld <= 1'b0;
        end else begin
            r1_vld <= i_valid;
            if (i_valid) begin
                r1_bin <= gray_bin;
            end
        end
    end

    // Stage 2: compare against the reference word; the reference always follows
    // the newest word so the checker resyncs right after an illegal jump.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_EMPTY;
            ref_bin      <= '0;
            o_bin        <= '0;
            o_valid      <= 1'b0;
            o_step_up    <= 1'b0;
            o_step_dn    <= 1'b0;
            o_hold       <= 1'b0;
            o_err        <= 1'b0;
            o_err_sticky <= 1'b0;
`ifdef GRAY_CHK_ERRCNT_EN
            o_err_cnt    <= '0;
`endif
        end else begin
            o_valid   <= 1'b0;
            o_step_up <= 1'b0;
            o_step_dn <= 1'b0;
            o_hold    <= 1'b0;
            o_err     <= 1'b0;
            if (i_clr) begin
                state        <= S_EMPTY;
                o_err_sticky <= 1'b0;
`ifdef GRAY_CHK_ERRCNT_EN
                o_err_cnt    <= '0;
`endif
            end else if (r1_vld) begin
                o_valid <= 1'b1;
                o_bin   <= r1_bin;
                ref_bin <= r1_bin;
                case (state)
                    S_EMPTY: begin
                        state <= S_LOCK;
                    end
                    S_LOCK: begin
                        if (diff == NBIT'(1)) begin
                            o_step_up <= 1'b1;
                        end else if (diff == '1) begin
                            o_step_dn <= 1'b1;
                        end else if (diff == '0) begin
                            o_hold <= 1'b1;
                        end else begin
                            o_err        <= 1'b1;
                            o_err_sticky <= 1'b1;
`ifdef GRAY_CHK_ERRCNT_EN
                            if (o_err_cnt != '1) begin
                                o_err_cnt <= o_err_cnt + CW'(1);
                            end
`endif
                        end
                    end
                    default: begin
                        state <= S_EMPTY;
                    end
                endcase
            end
        end
    end

`ifndef GRAY_CHK_ERRCNT_EN
    logic [CW-1:0] unused_cw;
    assign unused_cw = '0;
`endif

endmodule
